// File: rtl/uart_rx.sv
// UART receiver on the 16x-oversampled clock: start/data/[parity]/stop framing,
// parallel byte with ready flag, framing/overrun/parity error flags.
// Define UART_RX_PARITY_EN to add an odd-parity bit after the data bits;
// without it parity_err is tied low.
module uart_rx #(
    parameter int unsigned DATA_BITS   = 8,
    parameter int unsigned SYNC_STAGES = 2
) (
    input  logic                 mclkx16,
    input  logic                 reset,
    input  logic                 rx,
    input  logic                 read,
    output logic [DATA_BITS-1:0] data,
    output logic                 rxrdy,
    output logic                 framing_err,
    output logic                 overrun,
    output logic                 parity_err
);

    localparam int unsigned TICK_W = 4;
    localparam int unsigned BIT_W  = $clog2(DATA_BITS + 1);

    localparam logic [2:0] IDLE      = 3'd0;
    localparam logic [2:0] START     = 3'd1;
    localparam logic [2:0] DATA      = 3'd2;
    localparam logic [2:0] PARITY    = 3'd3;
    localparam logic [2:0] STOP      = 3'd4;
    localparam logic [2:0] LOAD      = 3'd5;
    localparam logic [2:0] WAIT_HIGH = 3'd6;

    logic [SYNC_STAGES-1:0] r_sync;
    logic [2:0]             r_state;
    logic [2:0]             w_next_state;
    logic [TICK_W-1:0]      r_tick;
    logic [BIT_W-1:0]       r_bitcnt;
    logic [DATA_BITS-1:0]   r_shift;
    logic                   r_stop;
    logic [DATA_BITS-1:0]   r_data;
    logic                   r_rxrdy;
    logic                   r_framing_err;
    logic                   r_overrun;
    logic                   w_rxs;
    logic                   w_tick_mid;
    logic                   w_tick_end;
    logic                   w_last_bit;

    assign w_rxs      = r_sync[SYNC_STAGES-1];
    assign w_tick_mid = (r_tick == TICK_W'(7));
    assign w_tick_end = (r_tick == TICK_W'(15));
    assign w_last_bit = (r_bitcnt == BIT_W'(DATA_BITS - 1));

    assign data        = r_data;
    assign rxrdy       = r_rxrdy;
    assign framing_err = r_framing_err;
    assign overrun     = r_overrun;

    // Bring the asynchronous line into the clock domain; idle-high on reset.
    always_ff @(posedge mclkx16 or posedge reset) begin
        if (reset) begin
            r_sync <= '1;
        end else begin
            r_sync <= {r_sync[SYNC_STAGES-2:0], rx};
        end
    end

    // FSM state register.
    always_ff @(posedge mclkx16 or posedge reset) begin
        if (reset) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    // Next-state logic; every decision is taken at a bit midpoint.
    always_comb begin
        w_next_state = r_state;
        case (r_state)
            IDLE: begin
                if (!w_rxs) w_next_state = START;
            end
            START: begin
                if (w_tick_mid) w_next_state = w_rxs ? IDLE : DATA;
            end
            DATA: begin
                if (w_tick_end && w_last_bit) begin
`ifdef UART_RX_PARITY_EN
                    w_next_state = PARITY;
`else
                    w_next_state = STOP;
`endif
                end
            end
            PARITY: begin
                if (w_tick_end) w_next_state = STOP;
            end
            STOP: begin
                if (w_tick_end) w_next_state = LOAD;
            end
            LOAD: begin
                w_next_state = r_stop ? IDLE : WAIT_HIGH;
            end
            WAIT_HIGH: begin
                if (w_rxs) w_next_state = IDLE;
            end
            default: w_next_state = IDLE;
        endcase
    end

    // Tick and bit counters, shift register and stop-bit sample.
    always_ff @(posedge mclkx16 or posedge reset) begin
        if (reset) begin
            r_tick   <= '0;
            r_bitcnt <= '0;
            r_shift  <= '0;
            r_stop   <= 1'b1;
        end else begin
            if (w_next_state != r_state) begin
                r_tick <= '0;
            end else begin
                r_tick <= TICK_W'(r_tick + 1'b1);
            end

            if (r_state != DATA) begin
                r_bitcnt <= '0;
            end else if (w_tick_end) begin
                r_bitcnt <= BIT_W'(r_bitcnt + 1'b1);
                r_shift  <= {w_rxs, r_shift[DATA_BITS-1:1]};
            end

            if (r_state == STOP && w_tick_end) begin
                r_stop <= w_rxs;
            end
        end
    end

`ifdef UART_RX_PARITY_EN
    logic r_par_bit;
    logic r_parity_err;

    assign parity_err = r_parity_err;

    // Capture the parity bit and check odd parity when the byte is loaded.
    always_ff @(posedge mclkx16 or posedge reset) begin
        if (reset) begin
            r_par_bit    <= 1'b0;
            r_parity_err <= 1'b0;
        end else begin
            if (r_state == PARITY && w_tick_end) begin
                r_par_bit <= w_rxs;
            end
            if (r_state == LOAD) begin
                r_parity_err <= ~((^r_shift) ^ r_par_bit);
            end else if (read && r_rxrdy) begin
                r_parity_err <= 1'b0;
            end
        end
    end
`else
    assign parity_err = 1'b0;
`endif

    // Host-facing byte and flags; a LOAD takes priority over a same-cycle read.
    always_ff @(posedge mclkx16 or posedge reset) begin
        if (reset) begin
            r_data        <= '0;
            r_rxrdy       <= 1'b0;
            r_framing_err <= 1'b0;
            r_overrun     <= 1'b0;
        end else if (r_state == LOAD) begin
            r_data        <= r_shift;
            r_rxrdy       <= 1'b1;
            r_framing_err <= ~r_stop;
            if (r_rxrdy && !read) begin
                r_overrun <= 1'b1;
            end
        end else if (read && r_rxrdy) begin
            r_rxrdy       <= 1'b0;
            r_framing_err <= 1'b0;
            r_overrun     <= 1'b0;
        end
    end

endmodule
